pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Controller for the other end of the PLL's rst/locked interface.
- Drives the PLL reset and watches the PLL lock output.
- Releases the system reset only after lock has been stable for a set time; retries when lock times out and restarts when lock is lost.
- Runs on the free-running 50 MHz board clock that also feeds the PLL reference, never on a PLL output.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset pulse (>=1)
LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before retry (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release
MAX_RETRY, 8, lock timeouts tolerated before FAIL (1..15)
CNT_W, 16, width of the shared cycle counter; must hold max of the three cycle parameters

Ports:
clkin  in  1  board reference clock (50 MHz), sole clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to clkin
pll_rst  out  1  PLL reset, active high, registered
sys_rst_n  out  1  system reset, active low, registered
ready  out  1  high only in RUN
fail  out  1  sticky, high in FAIL
retry_cnt  out  4  lock timeouts since rst_n
loss_cnt  out  8  lock losses from RUN, saturates at 255
state  out  3  current state encoding, for debug/LEDs

Behaviour:
- Reset (rst_n low, async):
  - state=RESET, counter=0; pll_rst=1; sys_rst_n=0; ready=0; fail=0; retry_cnt=0; loss_cnt=0.
  - Synchronizer flops cleared to 0.
- pll_locked passes through a 2-flop synchronizer. All decisions use lk_s, the second flop. Input-to-decision latency is 2 cycles.
- States, with encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET:
  - pll_rst=1, sys_rst_n=0; counter increments each cycle.
  - When counter==RST_CYCLES-1: go to WAIT_LOCK, counter=0.
- WAIT_LOCK:
  - pll_rst=0, sys_rst_n=0.
  - If lk_s=1: go to STABLE, counter=0.
  - Else if counter==LOCK_TIMEOUT-1: retry_cnt+1.
    - If the new retry_cnt==MAX_RETRY, go to FAIL; else go to RESET. Counter=0.
  - lk_s wins when it coincides with the timeout cycle.
- STABLE:
  - pll_rst=0, sys_rst_n=0.
  - If lk_s=0: go back to WAIT_LOCK, counter=0. The timeout restarts and no retry is counted.
  - Else if counter==STABLE_CYCLES-1: go to RUN.
- RUN:
  - sys_rst_n=1 and ready=1, registered and asserted on the first RUN cycle.
  - If lk_s=0: loss_cnt+1 (saturating), go to RESET, counter=0.
  - sys_rst_n and ready drop in the cycle the state leaves RUN, i.e. 3 clkin after pll_locked falls.
- FAIL:
  - pll_rst=1, sys_rst_n=0, fail=1.
  - Terminal; only rst_n exits.
- retry_cnt is not cleared on reaching RUN; it is diagnostic history since rst_n.
- Glitches on pll_locked shorter than one clkin may be missed; this is acceptable.
- Outputs are all registered, with no combinational path from pll_locked.
- rst_n asserted mid-operation forces the reset values immediately; the sequence restarts from RESET on release.

Decomposition:
- Package pll_ctrl_pkg holds:
  - the state enum, with encodings 0-4 as above;
  - widths for retry_cnt (4) and loss_cnt (8).
- Sub-module sync2 (2-flop synchronizer, async active-low clear to 0) is reused for other async inputs in the design.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRY=3.
1. Normal lock: rst_n release, pll_locked rises at cycle 20 and stays -> pll_rst high for exactly cycles 0-3; sys_rst_n rises at cycle 20+2+16+1 (±1 per registered edge, checked against the model); ready=1; retry_cnt=0.
2. Bounce in STABLE: locked high 10 cycles, low 1 cycle, high again -> return to WAIT_LOCK; STABLE restarts; sys_rst_n goes high only after a further 16 clean cycles; retry_cnt=0.
3. Timeout retry: locked held low -> pll_rst re-pulses 4 cycles after every 100-cycle wait; retry_cnt goes 1,2; on the 3rd timeout state=4, fail=1, pll_rst=1 permanently.
4. Loss of lock: reach RUN, drop pll_locked -> sys_rst_n=0 exactly 3 cycles later; loss_cnt=1; pll_rst pulses 4 cycles; relock reaches RUN again.
5. Saturation: force 300 lock losses -> loss_cnt stays at 255.
6. Mid-run async reset: assert rst_n low in RUN between clock edges -> sys_rst_n=0, pll_rst=1, counters 0 with no clock edge; sequence restarts from RESET after release.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types and widths for the PLL reset controller
// Contents:
//   pll_state_t : controller state; encoding is visible on the state debug port
//   RETRY_W     : width of the lock-timeout counter
//   LOSS_W      : width of the saturating lock-loss counter
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with asynchronous active-low clear
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset sequencer with lock qualification, retry and loss tracking
// Ports:
//   clkin      : free-running board reference clock, sole clock
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL lock indication, asynchronous to clkin
//   pll_rst    : PLL reset, active high
//   sys_rst_n  : system reset, active low, released only in RUN
//   ready      : high only in RUN
//   fail       : high in FAIL (terminal until rst_n)
//   retry_cnt  : lock timeouts since rst_n
//   loss_cnt   : lock losses from RUN, saturating
//   state      : current state encoding
module pll_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 8,
    parameter int CNT_W         = 16
) (
    input  logic               clkin,
    input  logic               rst_n,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    pll_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic [LOSS_W-1:0]  loss_d;
    logic               lk_s;

    sync2 u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_cnt;
        loss_d  = loss_cnt;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen on the timeout cycle still counts as a lock.
                if (lk_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_cnt + RETRY_W'(1);
                    state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                    cnt_d   = '0;
                end
            end
            ST_STABLE: begin
                // A bounce returns to WAIT_LOCK with a fresh timeout, not a retry.
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lk_s) begin
                    loss_d  = (loss_cnt == '1) ? loss_cnt : loss_cnt + LOSS_W'(1);
                    state_d = ST_RESET;
                end
            end
            ST_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            loss_cnt  <= loss_d;
            pll_rst   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            sys_rst_n <= (state_d == ST_RUN);
            ready     <= (state_d == ST_RUN);
            fail      <= (state_d == ST_FAIL);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

    localparam int RST_C = 4;
    localparam int TO_C  = 100;
    localparam int ST_C  = 16;
    localparam int MAXR  = 3;

    localparam int PH_RESET  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;
    logic [18:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   m_phase, m_elapsed, m_retry, m_loss;
    logic m_s1, m_s2;

    pll_reset_ctrl #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (TO_C),
        .STABLE_CYCLES (ST_C),
        .MAX_RETRY     (MAXR),
        .CNT_W         (16)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state      (state)
    );

    always #10 clkin = ~clkin;

    assign dut_vec = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt, state};

    task automatic model_clear();
        m_phase = PH_RESET; m_elapsed = 0; m_retry = 0; m_loss = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    task automatic enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endtask

    // Reference: phases advance on time spent in the phase and on the
    // lock level observed two clock samples earlier.
    task automatic model_edge();
        logic lk;
        int   spent;
        if (!rst_n) begin
            model_clear();
            return;
        end
        lk   = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        spent     = m_elapsed + 1;
        m_elapsed = spent;
        case (m_phase)
            PH_RESET:  if (spent == RST_C) enter(PH_WAIT);
            PH_WAIT: begin
                if (lk) enter(PH_STABLE);
                else if (spent == TO_C) begin
                    m_retry++;
                    enter(m_retry == MAXR ? PH_FAIL : PH_RESET);
                end
            end
            PH_STABLE: begin
                if (!lk) enter(PH_WAIT);
                else if (spent == ST_C) enter(PH_RUN);
            end
            PH_RUN: begin
                if (!lk) begin
                    m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                    enter(PH_RESET);
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [18:0] exp_vec();
        return {(m_phase == PH_RESET) || (m_phase == PH_FAIL), m_phase == PH_RUN,
                m_phase == PH_RUN, m_phase == PH_FAIL, 4'(m_retry), 8'(m_loss), 3'(m_phase)};
    endfunction

    task automatic tick(input logic nxt);
        @(posedge clkin);
        model_edge();
        #1 pll_locked = nxt;
        @(negedge clkin);
        cyc++;
    endtask

    task automatic do_reset(input logic lk_init);
        rst_n = 1'b0;
        pll_locked = lk_init;
        for (int i = 0; i < 3; i++) tick(lk_init);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_ready(output bit ok);
        for (int k = 0; k < 300 && !ready; k++) tick(1'b1);
        ok = ready;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_clear();
        #4;
        n_checks++;
        if (dut_vec !== 19'h40000) begin
            n_fail++; $display("FAIL reset_async dut=%h required=%h", dut_vec, 19'h40000);
        end
        for (int i = 0; i < 3; i++) tick(1'b1);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_held dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_normal_lock();
        int rise, nh, last_hi;
        do_reset(1'b0);
        rise = -1; nh = 0; last_hi = -1;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) tick(c >= 20);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL normal_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (pll_rst) begin nh++; last_hi = c; end
            if (sys_rst_n && rise < 0) rise = c;
        end
        n_checks++;
        if (nh !== 4 || last_hi !== 3) begin
            n_fail++; $display("FAIL normal_pll_rst high=%0d last=%0d required=4/3", nh, last_hi);
        end
        n_checks++;
        if (rise !== 20 + 2 + ST_C + 1) begin
            n_fail++; $display("FAIL normal_release cycle=%0d required=%0d", rise, 20 + 2 + ST_C + 1);
        end
        n_checks++;
        if (ready !== 1'b1 || retry_cnt !== 4'd0) begin
            n_fail++; $display("FAIL normal_final ready=%b retry=%0d required=1/0", ready, retry_cnt);
        end
    endtask

    task automatic test_bounce();
        int rise;
        do_reset(1'b0);
        rise = -1;
        for (int c = 1; c <= 70; c++) begin
            tick((c >= 20) && (c != 30));
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c == 33) begin
                n_checks++;
                if (state !== 3'd1) begin
                    n_fail++; $display("FAIL bounce_back state=%0d required=1", state);
                end
            end
            if (sys_rst_n && rise < 0) rise = c;
        end
        n_checks++;
        if (rise !== 50 || retry_cnt !== 4'd0) begin
            n_fail++; $display("FAIL bounce_release cycle=%0d retry=%0d required=50/0", rise, retry_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset(1'b0);
        for (int c = 1; c <= 360; c++) begin
            tick(1'b0);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL timeout_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c == 103 || c == 104 || c == 208 || c == 311 || c == 312) begin
                n_checks++;
                case (c)
                    103: if (pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin
                        n_fail++; $display("FAIL timeout_wait103 pll_rst=%b retry=%0d required=0/0", pll_rst, retry_cnt); end
                    104: if (pll_rst !== 1'b1 || retry_cnt !== 4'd1) begin
                        n_fail++; $display("FAIL timeout_retry1 pll_rst=%b retry=%0d required=1/1", pll_rst, retry_cnt); end
                    208: if (pll_rst !== 1'b1 || retry_cnt !== 4'd2) begin
                        n_fail++; $display("FAIL timeout_retry2 pll_rst=%b retry=%0d required=1/2", pll_rst, retry_cnt); end
                    311: if (state !== 3'd1 || fail !== 1'b0) begin
                        n_fail++; $display("FAIL timeout_pre_fail state=%0d fail=%b required=1/0", state, fail); end
                    default: if (state !== 3'd4 || fail !== 1'b1 || retry_cnt !== 4'd3) begin
                        n_fail++; $display("FAIL timeout_fail state=%0d fail=%b retry=%0d required=4/1/3", state, fail, retry_cnt); end
                endcase
            end
        end
        for (int c = 0; c < 20; c++) tick(1'b1);
        n_checks++;
        if (state !== 3'd4 || pll_rst !== 1'b1 || fail !== 1'b1) begin
            n_fail++; $display("FAIL fail_terminal state=%0d pll_rst=%b fail=%b required=4/1/1", state, pll_rst, fail);
        end
    endtask

    task automatic test_loss();
        bit ok;
        int nh;
        do_reset(1'b1);
        wait_ready(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL loss_reach_run ready=%b required=1", ready); end
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        n_checks++;
        if (sys_rst_n !== 1'b1) begin n_fail++; $display("FAIL loss_early sys_rst_n=%b required=1", sys_rst_n); end
        tick(1'b0);
        n_checks++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || loss_cnt !== 8'd1) begin
            n_fail++; $display("FAIL loss_drop sys_rst_n=%b ready=%b loss=%0d required=0/0/1", sys_rst_n, ready, loss_cnt);
        end
        nh = 0;
        for (int c = 0; c < 10; c++) begin
            if (pll_rst) nh++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL loss_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
            end
            tick(1'b0);
        end
        n_checks++;
        if (nh !== RST_C) begin n_fail++; $display("FAIL loss_pulse high=%0d required=%0d", nh, RST_C); end
        wait_ready(ok);
        n_checks++;
        if (!ok || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL loss_relock dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            wait_ready(ok);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL sat_ready_timeout iter=%0d ready=%b required=1", i, ready);
                break;
            end
            for (int k = 0; k < 10 && (ready || k == 0); k++) tick(1'b0);
            n_checks++;
            if (ready !== 1'b0 || loss_cnt !== 8'((i < 255) ? i : 255)) begin
                n_fail++; $display("FAIL sat_iter%0d ready=%b loss=%0d required=0/%0d", i, ready, loss_cnt, (i < 255) ? i : 255);
            end
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL sat_final dut=%h model=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset(1'b1);
        wait_ready(ok);
        tick(1'b1);
        n_checks++;
        if (!ok || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_reach_run ready=%b required=1", ready); end
        @(posedge clkin);
        model_edge();
        #3 rst_n = 1'b0;
        #2;
        model_clear();
        n_checks++;
        if (dut_vec !== 19'h40000 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL arst_immediate dut=%h required=%h", dut_vec, 19'h40000);
        end
        @(negedge clkin);
        tick(1'b1);
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            tick(1'b1);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL arst_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
            end
            if (c == 3 || c == 4) begin
                n_checks++;
                if (pll_rst !== (c == 3)) begin
                    n_fail++; $display("FAIL arst_restart c=%0d pll_rst=%b required=%b", c, pll_rst, c == 3);
                end
            end
        end
    endtask

    task automatic test_random();
        logic lk;
        int   hold;
        for (int run = 0; run < 4; run++) begin
            do_reset(1'($urandom_range(0, 1)));
            lk = 1'b0;
            hold = 0;
            for (int c = 1; c <= 400; c++) begin
                if (hold == 0) begin
                    lk   = 1'($urandom_range(0, 1));
                    hold = (run[0]) ? $urandom_range(1, 6) : $urandom_range(1, 60);
                end
                hold--;
                tick(lk);
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random_r%0d_c%0d dut=%h model=%h", run, c, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_normal_lock();
        test_bounce();
        test_timeout();
        test_loss();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
